// File: rtl/bft_pkg.sv
// Shared definitions for the BFT stream packetizer: packet field layout,
// control-port constant, FSM states and credit capacity.
package bft_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int FREESPACE_UPDATE_SIZE = 64;

  localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
  localparam int CREDIT_CAP  = 1 << NUM_ADDR_BITS;

  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 43;
  localparam int PORT_LSB  = 39;
  localparam int ADDR_LSB  = 32;

  localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Freespace updates arrive on the control port; the freed count sits in the low payload byte.
  function automatic logic is_update(input logic [PACKET_BITS-1:0] pkt);
    return pkt[VALID_BIT] && (pkt[PORT_LSB +: NUM_PORT_BITS] == CTRL_PORT);
  endfunction

  function automatic logic [7:0] freed_count(input logic [PACKET_BITS-1:0] pkt);
    return pkt[7:0];
  endfunction

endpackage

// File: rtl/bft_credit_counter.sv
// Sender-side credit register: load to full capacity, decrement per sent word,
// add freed entries from returned updates, saturating at capacity.
module bft_credit_counter
  import bft_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   dec_i,
  input  logic [7:0]             add_i,
  output logic [CREDIT_BITS-1:0] count_o,
  output logic                   zero_o
);

  localparam logic [CREDIT_BITS-1:0] CAP     = CREDIT_BITS'(CREDIT_CAP);
  localparam logic [CREDIT_BITS+1:0] CAP_EXT = (CREDIT_BITS+2)'(CREDIT_CAP);

  logic [CREDIT_BITS-1:0] count_q, count_d;
  logic [CREDIT_BITS+1:0] sum;

  always_comb begin
    sum = {2'b00, count_q} - {{(CREDIT_BITS+1){1'b0}}, dec_i} + {2'b00, add_i};
    if (load_i) begin
      count_d = CAP;
    end else if (sum > CAP_EXT) begin
      count_d = CAP;
    end else begin
      count_d = sum[CREDIT_BITS-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/bft_stream_packetizer.sv
// Stream-to-BFT-packet engine with credit flow control toward one destination.
// Optional statistics counters are enabled by defining BFT_PACKETIZER_STATS_EN.
//
// state    | meaning
// IDLE     | waiting for ap_start, no acks
// RUN      | accepting words while credits remain
// STALL    | out of credits, waiting for a freespace update
// HOLD     | network resend in progress, output forced to zero
module bft_stream_packetizer
  import bft_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic [PAYLOAD_BITS-1:0]  din_user,
  input  logic                     vld_user,
  output logic                     ack_user,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  output logic [CREDIT_BITS-1:0]   credit_count
`ifdef BFT_PACKETIZER_STATS_EN
  ,
  output logic [31:0]              stat_sent,
  output logic [31:0]              stat_stall
`endif
);

  state_t                   state_q;
  logic [NUM_LEAF_BITS-1:0] leaf_q;
  logic [NUM_PORT_BITS-1:0] port_q;
  logic [NUM_ADDR_BITS-1:0] addr_q;
  logic [PACKET_BITS-1:0]   dout_q;

  logic       cred_zero;
  logic       start_ok;
  logic [7:0] add_amt;
  logic       stall_next;

  assign start_ok = (state_q == ST_IDLE) && ap_start;
  assign add_amt  = ((state_q != ST_IDLE) && is_update(din_leaf_bft2interface))
                    ? freed_count(din_leaf_bft2interface) : 8'd0;
  assign ack_user = (state_q == ST_RUN) && vld_user && !cred_zero && !reset;

  // The last credit goes out with no update arriving alongside it.
  assign stall_next = ack_user && (credit_count == CREDIT_BITS'(1)) && (add_amt == 8'd0);

  bft_credit_counter u_credit (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (start_ok),
    .dec_i   (ack_user),
    .add_i   (add_amt),
    .count_o (credit_count),
    .zero_o  (cred_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      leaf_q  <= '0;
      port_q  <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      dout_q <= ack_user ? {1'b1, leaf_q, port_q, addr_q, din_user} : '0;
      case (state_q)
        ST_IDLE: begin
          if (ap_start) begin
            leaf_q  <= cfg_dest_leaf;
            port_q  <= cfg_dest_port;
            addr_q  <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (ack_user) addr_q <= addr_q + 1'b1;
          if (resend)          state_q <= ST_HOLD;
          else if (stall_next) state_q <= ST_STALL;
        end
        ST_STALL: begin
          if (resend)          state_q <= ST_HOLD;
          else if (!cred_zero) state_q <= ST_RUN;
        end
        ST_HOLD: begin
          if (!resend) state_q <= cred_zero ? ST_STALL : ST_RUN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A word registered during the resend cycle surfaces in HOLD and is dropped there.
  assign dout_leaf_interface2bft = (resend || (state_q == ST_HOLD)) ? '0 : dout_q;

`ifdef BFT_PACKETIZER_STATS_EN
  logic [31:0] stat_sent_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      stat_sent_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (dout_leaf_interface2bft[VALID_BIT]) stat_sent_q <= stat_sent_q + 32'd1;
      if ((state_q == ST_STALL) && vld_user && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_sent  = stat_sent_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
